// File: rtl/s526_key_sequencer.sv
// Unlock-key transmitter for the locked s526 core: plays the key on G2..G0, then passes functional stimulus through.
// Optional TRILOCK_LFSR_KEY_EN macro replaces the KEY_SEQ table with a seeded 16-bit LFSR symbol source.
module s526_key_sequencer #(
  parameter int                   KEY_LEN  = 4,
  parameter logic [KEY_LEN*3-1:0] KEY_SEQ  = 12'hA5C,
  parameter logic [15:0]          KEY_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       func_G0,
  input  logic       func_G1,
  input  logic       func_G2,
  output logic       G0,
  output logic       G1,
  output logic       G2,
  output logic       busy,
  output logic       unlocked,
  output logic [7:0] key_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_FUNC = 2'd2;
  localparam logic [7:0] LAST_IDX = 8'(KEY_LEN - 1);

  logic [1:0] state;
  logic [7:0] next_idx;
  logic [2:0] first_sym;
  logic [2:0] next_sym;

  assign next_idx = key_idx + 8'd1;

`ifdef TRILOCK_LFSR_KEY_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Taps x^16+x^14+x^13+x^11 -> bits 15,13,12,10; shift left, feedback into bit 0.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign first_sym = KEY_SEED[2:0];
  assign next_sym  = lfsr_next[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= KEY_SEED;
    end else if (!abort) begin
      if (state == S_IDLE && start)
        lfsr <= KEY_SEED;
      else if (state == S_KEY)
        lfsr <= lfsr_next;
    end
  end
`else
  assign first_sym = KEY_SEQ[2:0];

  always_comb begin
    next_sym = KEY_SEQ[2:0];
    for (int i = 0; i < KEY_LEN; i++)
      if (next_idx == 8'(i))
        next_sym = KEY_SEQ[3*i +: 3];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state        <= S_IDLE;
      {G2, G1, G0} <= 3'b001;
      busy         <= 1'b0;
      unlocked     <= 1'b0;
      key_idx      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_KEY;
            {G2, G1, G0} <= first_sym;
            busy         <= 1'b1;
            key_idx      <= 8'd0;
          end
        end
        S_KEY: begin
          if (key_idx == LAST_IDX) begin
            state        <= S_FUNC;
            {G2, G1, G0} <= {func_G2, func_G1, func_G0};
            busy         <= 1'b0;
            unlocked     <= 1'b1;
            key_idx      <= 8'd0;
          end else begin
            {G2, G1, G0} <= next_sym;
            key_idx      <= next_idx;
          end
        end
        S_FUNC: begin
          {G2, G1, G0} <= {func_G2, func_G1, func_G0};
        end
        default: begin
          state        <= S_IDLE;
          {G2, G1, G0} <= 3'b001;
          busy         <= 1'b0;
          unlocked     <= 1'b0;
          key_idx      <= 8'd0;
        end
      endcase
    end
  end

endmodule
